// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter state enum, the FIFO geometry defaults shared with the
// FIFO itself, and the helper that sizes the FIFO occupancy counter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_FIFO_DEPTH = 16;

   // The occupancy counter must represent 0..FIFO_DEPTH inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter.
// slave  : the arbiter (consumes requests and FIFO occupancy, drives the FIFO).
// master : the environment (producers and FIFO status).
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

   localparam int CNT_W = cnt_width(FIFO_DEPTH);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [CNT_W-1:0]              fifo_counter;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;

   modport master (
      output req_valid, req_data, fifo_counter,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant, busy
   );

   modport slave (
      input  req_valid, req_data, fifo_counter,
      output req_ready, fifo_wr_en, fifo_wr_data, grant, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// after rr_ptr, wrapping modulo NUM_REQ, plus a flag that any bit is set.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               any_req
);

   logic [PTR_W-1:0] idx;

   // Scan from the farthest offset back to rr_ptr so the nearest hit wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path can
      // leave a value unassigned and infer a latch.
      winner  = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among
// NUM_REQ producers. A granted producer keeps the port for up to BURST_MAX
// beats; the FIFO write enable and data are registered, and the arbiter
// keeps the FIFO from overflowing by counting its own in-flight write on top
// of fifo_counter.
// Optional: define FIFO_WR_ARB_STATS_EN to add per-producer saturating beat
// counters (beat_count) with a synchronous clear (stats_clr).
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int BURST_MAX  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic                  stats_clr,
   output logic [NUM_REQ*16-1:0] beat_count,
`endif
   fifo_wr_arbiter_if.slave      bus
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int CNT_W  = cnt_width(FIFO_DEPTH);
   localparam int SUM_W  = CNT_W + 1;
   localparam int BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

   arb_state_e            state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      owner;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W-1:0]      next_ptr;
   logic                  any_req;
   logic [BEAT_W-1:0]     beat_cnt;
   logic                  wr_en_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [DATA_WIDTH-1:0] owner_data;
   logic [NUM_REQ-1:0]    grant_q;
   logic                  busy_q;
   logic [NUM_REQ-1:0]    ready;
   logic [SUM_W-1:0]      occ_sum;
   logic                  space_ok;
   logic                  owner_valid;
   logic                  transfer;
   logic                  last_beat;
   logic                  end_burst;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // Occupancy plus the write already registered toward the FIFO; one extra
   // bit so the sum cannot wrap. Concurrent reads are ignored (conservative).
   assign occ_sum  = SUM_W'(bus.fifo_counter) + SUM_W'(wr_en_q);
   assign space_ok = occ_sum < SUM_W'(FIFO_DEPTH);

   assign owner_valid = bus.req_valid[owner];
   assign owner_data  = bus.req_data[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
   assign transfer    = (state == BURST) && owner_valid && space_ok;
   assign last_beat   = (beat_cnt == BEAT_W'(BURST_MAX - 1));
   assign end_burst   = (state == BURST) && ((transfer && last_beat) || !owner_valid);
   assign next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

   // Only the owner sees ready, and only while the FIFO has room; ready is
   // independent of valid so producers may present data after seeing it.
   always_comb begin
      ready = '0;
      if (state == BURST) begin
         ready[owner] = space_ok;
      end
   end

   // Arbitration FSM with registered FIFO write port, grant and busy.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block updates from pre-edge values regardless of statement order.
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         beat_cnt  <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wr_en_q <= 1'b0;
               if (any_req) begin
                  state    <= BURST;
                  owner    <= winner;
                  beat_cnt <= '0;
                  grant_q  <= NUM_REQ'(1) << winner;
                  busy_q   <= 1'b1;
               end
            end
            BURST: begin
               wr_en_q <= transfer;
               if (transfer) begin
                  wr_data_q <= owner_data;
               end
               if (end_burst) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr;
                  beat_cnt <= '0;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_wr_data = wr_data_q;
   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];

   // Per-producer saturating count of accepted beats; clear beats increment.
   always_ff @(posedge clk) begin
      // NOTE: these counters are software-visible state, so unlike a data
      // buffer they are reset explicitly.
      if (!rst_n || stats_clr) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (transfer && (cnt_q[owner] != 16'hFFFF)) begin
         cnt_q[owner] <= cnt_q[owner] + 16'd1;
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      beat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beat_count[i*16 +: 16] = cnt_q[i];
      end
   end
`endif

endmodule
